// File: rtl/branch_condition_sequencer.sv
// branch_condition_sequencer
// Program-counter and branch-condition stage of the 8-bit microprocessor.
// Holds the ALU flags, presents the condition vector and select lines to the
// external 8-to-1 condition multiplexer, samples its Y output and steps the
// program counter.
// Optional feature macro: BRANCH_CALL_EN adds a one-entry call/return
// register. Without it, CALL acts as BRANCH and RET acts as NEXT.
module branch_condition_sequencer #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_instr_valid,
   output logic                  o_instr_ready,
   input  logic [1:0]            i_op,
   input  logic [2:0]            i_cond_sel,
   input  logic [ADDR_WIDTH-1:0] i_jump_addr,
   input  logic                  i_flags_load,
   input  logic                  i_z_in,
   input  logic                  i_c_in,
   input  logic                  i_n_in,
   input  logic                  i_v_in,
   output logic [7:0]            o_cond_d,
   output logic                  o_sel_a,
   output logic                  o_sel_b,
   output logic                  o_sel_c,
   output logic                  o_en_bar,
   input  logic                  i_mux_y,
   output logic [ADDR_WIDTH-1:0] o_pc,
   output logic                  o_done,
   output logic                  o_taken
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SELECT,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      OP_NEXT,
      OP_BRANCH,
      OP_CALL,
      OP_RET
   } op_t;

   state_t                r_state;
   op_t                   r_op;
   logic [ADDR_WIDTH-1:0] r_jump_addr;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic [7:0]            r_cond_d;
   logic [2:0]            r_sel;
   logic                  r_en_bar;
   logic                  r_ready;
   logic                  r_done;
   logic                  r_taken;
`ifdef BRANCH_CALL_EN
   logic [ADDR_WIDTH-1:0] r_ret_addr;
   logic                  r_ret_valid;
`endif

   logic                  w_flow_op;
   logic                  w_taken;
   logic [ADDR_WIDTH-1:0] w_pc_inc;

   // Only BRANCH and CALL consult the multiplexer; Y is ignored otherwise.
   assign w_flow_op = (r_op == OP_BRANCH) || (r_op == OP_CALL);
   assign w_taken   = i_mux_y && w_flow_op;
   assign w_pc_inc  = r_pc + ADDR_WIDTH'(1);

   // The condition vector register doubles as the flag store: Z, C, N, V sit
   // on the even lanes and their complements on the odd lanes. Its reset value
   // leaves only the unconditional lane high until the first flag load.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cond_d <= 8'h80;
      end else if (i_flags_load) begin
         r_cond_d <= {1'b1, i_v_in, ~i_n_in, i_n_in, ~i_c_in, i_c_in, ~i_z_in, i_z_in};
      end
   end

   // Three-cycle sequencer: accept, select-and-decide, completion strobe.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_op        <= OP_NEXT;
         r_jump_addr <= '0;
         r_pc        <= '0;
         r_sel       <= 3'b000;
         r_en_bar    <= 1'b1;
         r_ready     <= 1'b1;
         r_done      <= 1'b0;
         r_taken     <= 1'b0;
`ifdef BRANCH_CALL_EN
         r_ret_addr  <= '0;
         r_ret_valid <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_instr_valid) begin
                  r_op        <= op_t'(i_op);
                  r_jump_addr <= i_jump_addr;
                  r_sel       <= i_cond_sel;
                  r_en_bar    <= ~((op_t'(i_op) == OP_BRANCH) || (op_t'(i_op) == OP_CALL));
                  r_ready     <= 1'b0;
                  r_state     <= ST_SELECT;
               end
            end
            ST_SELECT: begin
               if (w_taken) begin
                  r_pc    <= r_jump_addr;
                  r_taken <= 1'b1;
`ifdef BRANCH_CALL_EN
                  if (r_op == OP_CALL) begin
                     r_ret_addr  <= w_pc_inc;
                     r_ret_valid <= 1'b1;
                  end
               end else if ((r_op == OP_RET) && r_ret_valid) begin
                  r_pc        <= r_ret_addr;
                  r_ret_valid <= 1'b0;
                  r_taken     <= 1'b1;
`endif
               end else begin
                  r_pc    <= w_pc_inc;
                  r_taken <= 1'b0;
               end
               r_en_bar <= 1'b1;
               r_done   <= 1'b1;
               r_state  <= ST_DONE;
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign o_instr_ready = r_ready;
   assign o_cond_d      = r_cond_d;
   assign o_sel_a       = r_sel[0];
   assign o_sel_b       = r_sel[1];
   assign o_sel_c       = r_sel[2];
   assign o_en_bar      = r_en_bar;
   assign o_pc          = r_pc;
   assign o_done        = r_done;
   assign o_taken       = r_taken;

endmodule

// File: tb/tb_branch_condition_sequencer.sv
// tb_branch_condition_sequencer
// Drives branch_condition_sequencer with directed and random instructions,
// models the external 8-to-1 condition multiplexer, and compares against a
// behavioural model of program-counter flow. Honours BRANCH_CALL_EN.
module tb_branch_condition_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       instrValid;
   logic       instrReady;
   logic [1:0] op;
   logic [2:0] condSel;
   logic [7:0] jumpAddr;
   logic       flagsLoad;
   logic       zIn, cIn, nIn, vIn;
   logic [7:0] condD;
   logic       selA, selB, selC;
   logic       enBar;
   logic       muxY;
   logic [7:0] pc;
   logic       done;
   logic       taken;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   logic [7:0] mPc;
   logic [7:0] mRet;
   bit         mRetValid;
   bit         mLoaded;
   logic       mZ, mC, mN, mV;

   branch_condition_sequencer #(.ADDR_WIDTH(8)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_instr_valid (instrValid),
      .o_instr_ready (instrReady),
      .i_op          (op),
      .i_cond_sel    (condSel),
      .i_jump_addr   (jumpAddr),
      .i_flags_load  (flagsLoad),
      .i_z_in        (zIn),
      .i_c_in        (cIn),
      .i_n_in        (nIn),
      .i_v_in        (vIn),
      .o_cond_d      (condD),
      .o_sel_a       (selA),
      .o_sel_b       (selB),
      .o_sel_c       (selC),
      .o_en_bar      (enBar),
      .i_mux_y       (muxY),
      .o_pc          (pc),
      .o_done        (done),
      .o_taken       (taken)
   );

   // Free-running clock, 10 time-unit period
   always #5 clk = ~clk;

   // External 8-to-1 multiplexer: Y follows the selected channel when enabled
   assign muxY = enBar ? 1'b0 : condD[{selC, selB, selA}];

   // Compare one observed value against its expected value
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected condition vector from the model flags
   function automatic logic [7:0] expVec();
      if (!mLoaded) return 8'h80;
      return {1'b1, mV, ~mN, mN, ~mC, mC, ~mZ, mZ};
   endfunction

   // Synchronous reset and model reset
   task automatic applyReset();
      @(negedge clk);
      rst = 1'b1;
      instrValid = 1'b0;
      flagsLoad = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      mPc = 8'h00;
      mRet = 8'h00;
      mRetValid = 0;
      mLoaded = 0;
      {mZ, mC, mN, mV} = 4'b0000;
      checkOutput("rstPc", pc, 8'h00);
      checkOutput("rstReady", instrReady, 1);
      checkOutput("rstEnBar", enBar, 1);
      checkOutput("rstCondD", condD, 8'h80);
      checkOutput("rstDone", done, 0);
      checkOutput("rstTaken", taken, 0);
      checkOutput("rstSel", {selC, selB, selA}, 3'b000);
   endtask

   // Load the flag register for one edge
   task automatic loadFlags(input logic z, input logic c, input logic n, input logic v);
      @(negedge clk);
      flagsLoad = 1'b1;
      {zIn, cIn, nIn, vIn} = {z, c, n, v};
      @(posedge clk);
      {mZ, mC, mN, mV} = {z, c, n, v};
      mLoaded = 1;
      @(negedge clk);
      flagsLoad = 1'b0;
      checkOutput("flagVec", condD, expVec());
   endtask

   // Run one instruction through accept, select and done, checking each phase
   task automatic applyStimulus(input logic [1:0] iOp, input logic [2:0] iCs, input logic [7:0] iAddr,
                                input bit race, input logic [3:0] raceFlags, input bit holdValid);
      logic [7:0] vec;
      logic [7:0] expPc;
      logic       expTaken;
      int         waitCnt;
      waitCnt = 0;
      while (!instrReady && waitCnt < 8) begin
         @(negedge clk);
         waitCnt++;
      end
      if (!instrReady) checkOutput("readyTimeout", 0, 1);
      instrValid = 1'b1;
      op = iOp;
      condSel = iCs;
      jumpAddr = iAddr;
      @(posedge clk);
      @(negedge clk);
      checkOutput("selEnBar", enBar, !(iOp == 2'd1 || iOp == 2'd2));
      checkOutput("selLines", {selC, selB, selA}, iCs);
      checkOutput("selDone", done, 0);
      checkOutput("selReady", instrReady, 0);
      instrValid = holdValid;
      op = 2'($urandom);
      condSel = 3'($urandom);
      jumpAddr = 8'($urandom);
      if (race) begin
         flagsLoad = 1'b1;
         {zIn, cIn, nIn, vIn} = raceFlags;
      end
      vec = expVec();
      expTaken = (iOp == 2'd1 || iOp == 2'd2) && vec[iCs];
      expPc = mPc + 8'd1;
      if (expTaken) begin
`ifdef BRANCH_CALL_EN
         if (iOp == 2'd2) begin
            mRet = mPc + 8'd1;
            mRetValid = 1;
         end
`endif
         expPc = iAddr;
      end
`ifdef BRANCH_CALL_EN
      else if (iOp == 2'd3 && mRetValid) begin
         expPc = mRet;
         mRetValid = 0;
         expTaken = 1'b1;
      end
`endif
      mPc = expPc;
      @(posedge clk);
      if (race) begin
         {mZ, mC, mN, mV} = raceFlags;
         mLoaded = 1;
      end
      @(negedge clk);
      flagsLoad = 1'b0;
      checkOutput("donePc", pc, mPc);
      checkOutput("doneTaken", taken, expTaken);
      checkOutput("doneStrobe", done, 1);
      checkOutput("doneReady", instrReady, 0);
      checkOutput("doneEnBar", enBar, 1);
      checkOutput("doneCondD", condD, expVec());
      @(posedge clk);
      @(negedge clk);
      checkOutput("idleDone", done, 0);
      checkOutput("idleReady", instrReady, 1);
      checkOutput("idlePc", pc, mPc);
      checkOutput("idleEnBar", enBar, 1);
      instrValid = 1'b0;
   endtask

   // Abandon an instruction by asserting reset during SELECT
   task automatic resetDuringSelect();
      @(negedge clk);
      instrValid = 1'b1;
      op = 2'd1;
      condSel = 3'd7;
      jumpAddr = 8'h55;
      @(posedge clk);
      @(negedge clk);
      instrValid = 1'b0;
      rst = 1'b1;
      flagsLoad = 1'b1;
      {zIn, cIn, nIn, vIn} = 4'b1111;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      flagsLoad = 1'b0;
      mPc = 8'h00;
      mRet = 8'h00;
      mRetValid = 0;
      mLoaded = 0;
      {mZ, mC, mN, mV} = 4'b0000;
      checkOutput("midRstPc", pc, 8'h00);
      checkOutput("midRstDone", done, 0);
      checkOutput("midRstReady", instrReady, 1);
      checkOutput("midRstCondD", condD, 8'h80);
      @(posedge clk);
      @(negedge clk);
      checkOutput("midRstNoDone", done, 0);
      checkOutput("midRstPcHold", pc, 8'h00);
   endtask

   // Directed scenarios followed by random instruction traffic
   initial begin
      rst = 1'b1;
      instrValid = 1'b0;
      op = 2'd0;
      condSel = 3'd0;
      jumpAddr = 8'h00;
      flagsLoad = 1'b0;
      {zIn, cIn, nIn, vIn} = 4'b0000;

      applyReset();

      applyStimulus(2'd1, 3'd7, 8'hFF, 0, 4'b0000, 0);
      checkOutput("jumpToFF", pc, 8'hFF);
      applyStimulus(2'd0, 3'd3, 8'h12, 0, 4'b0000, 0);
      checkOutput("wrapPc", pc, 8'h00);
      checkOutput("wrapTaken", taken, 0);

      loadFlags(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(2'd1, 3'd0, 8'h3C, 0, 4'b0000, 0);
      checkOutput("branchZTaken", pc, 8'h3C);
      loadFlags(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(2'd1, 3'd0, 8'h3C, 0, 4'b0000, 0);
      checkOutput("branchZNot", pc, 8'h3D);

      applyStimulus(2'd1, 3'd2, 8'h77, 1, 4'b0100, 0);
      checkOutput("raceNotTaken", pc, 8'h3E);
      applyStimulus(2'd1, 3'd2, 8'h77, 0, 4'b0000, 0);
      checkOutput("raceNextTaken", pc, 8'h77);

      applyStimulus(2'd0, 3'd0, 8'h00, 0, 4'b0000, 1);
      checkOutput("holdOneInstr", pc, 8'h78);

      resetDuringSelect();

      applyStimulus(2'd1, 3'd7, 8'h10, 0, 4'b0000, 0);
      applyStimulus(2'd2, 3'd7, 8'h80, 0, 4'b0000, 0);
      checkOutput("callPc", pc, 8'h80);
      checkOutput("callTaken", taken, 1);
      applyStimulus(2'd3, 3'd0, 8'h00, 0, 4'b0000, 0);
`ifdef BRANCH_CALL_EN
      checkOutput("retPc", pc, 8'h11);
      checkOutput("retTaken", taken, 1);
`else
      checkOutput("retPc", pc, 8'h81);
      checkOutput("retTaken", taken, 0);
`endif
      applyStimulus(2'd3, 3'd0, 8'h00, 0, 4'b0000, 0);
`ifdef BRANCH_CALL_EN
      checkOutput("ret2Pc", pc, 8'h12);
`else
      checkOutput("ret2Pc", pc, 8'h82);
`endif
      checkOutput("ret2Taken", taken, 0);

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 2) == 0)
            loadFlags(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         applyStimulus(2'($urandom), 3'($urandom), 8'($urandom),
                       ($urandom_range(0, 3) == 0), 4'($urandom), ($urandom_range(0, 3) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/branch_condition_sequencer.md
# branch_condition_sequencer

- **Function:** program-counter and branch-condition stage of the programmable 8-bit microprocessor.
- **Upstream of the 8-line-to-1-line condition multiplexer:** holds the ALU status flags, drives the flag vector onto the mux data inputs, and drives the select lines and the active-low enable.
- **Downstream of the same multiplexer:** samples its `Y` output and decides the next program counter (increment, jump, or, optionally, call/return).
- **Throughput:** one instruction every three cycles under a valid/ready handshake.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: program counter and jump-target width.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `instr_valid`  in  1  instruction present on `op`/`cond_sel`/`jump_addr`.
- `instr_ready`  out  1  stage can accept an instruction.
- `op`  in  2  operation select:
  - 00 NEXT
  - 01 BRANCH
  - 10 CALL
  - 11 RET
- `cond_sel`  in  3  condition code, mux channel 0–7.
- `jump_addr`  in  ADDR_WIDTH  branch or call target.
- `flags_load`  in  1  capture `z_in`/`c_in`/`n_in`/`v_in` this edge.
- `z_in`, `c_in`, `n_in`, `v_in`  in  1 each  ALU flags.
- `cond_d`  out  8  flag vector to mux `D0`..`D7`.
- `sel_a`, `sel_b`, `sel_c`  out  1 each  mux select; `sel_a` is the LSB.
- `en_bar`  out  1  mux enable, active-low.
- `mux_y`  in  1  mux `Y` output (combinational return path).
- `pc`  out  ADDR_WIDTH  program counter.
- `done`  out  1  one-cycle completion strobe.
- `taken`  out  1  last instruction changed flow; valid while `done`=1.

## Operation
**Flag register (Z, C, N, V)**
- Loaded on any edge with `flags_load`=1, in any state.

**Flag vector `cond_d`**
- D0=Z, D1=~Z, D2=C, D3=~C, D4=N, D5=~N, D6=V, D7=1 (unconditional).

**FSM states**
- **IDLE:**
  - `instr_ready`=1.
  - On `instr_valid` && `instr_ready`: latch `op`, `cond_sel` and `jump_addr`, then go to SELECT.
- **SELECT:**
  - `{sel_c,sel_b,sel_a}` = latched `cond_sel`.
  - `en_bar`=0 for BRANCH and CALL; `en_bar`=1 for NEXT and RET.
  - At the end of the cycle, set `taken` = `mux_y` && (op is BRANCH or CALL).
  - In the same edge, update `pc`:
    - taken → `jump_addr`
    - RET → return target (see Configuration)
    - otherwise → `pc`+1
  - Go to DONE.
- **DONE:**
  - `done`=1 and `instr_ready`=0.
  - Go to IDLE on the next edge.

**Select lines outside SELECT**
- `sel_*` hold their last value and `en_bar`=1.

**Arithmetic**
- `pc`+1 is modulo 2^ADDR_WIDTH: 8'hFF → 8'h00.

**Simultaneous events**
- A flag load on the SELECT→DONE edge does not affect that decision; the mux saw the pre-edge flags.

## Timing
**Reset values**
- `pc`=0, flags=0, state=IDLE.
- `instr_ready`=1, `done`=0, `taken`=0, `en_bar`=1, `sel_*`=0.
- `cond_d`=8'h80.

**Latency**
- Accept at edge k.
- SELECT during cycle k..k+1.
- New `pc` and `taken` are visible after edge k+1.
- `done` is high for cycle k+1..k+2.
- Next accept is possible at edge k+3.

**Handshake**
- Inputs are sampled only on the accepting edge; they may change freely afterwards.
- `instr_valid` while `instr_ready`=0 is ignored and is not queued.

**Reset mid-operation**
- `rst` in SELECT or DONE abandons the instruction.
- No `pc` update beyond the reset value; no `done` pulse.
- `rst` has priority over `flags_load`.

## Configuration
**Macro:** `BRANCH_CALL_EN`

**Defined:**
- Adds a single-entry return register plus a valid bit, reset to 0 and invalid.
- A taken CALL stores `pc`+1 (wrapping) and sets the valid bit.
- RET loads `pc` from the return register, clears the valid bit, and sets `taken`=1.
- RET with the valid bit clear behaves as NEXT, with `taken`=0.
- A not-taken CALL behaves as NEXT.

**Undefined:**
- No return register.
- CALL behaves exactly as BRANCH.
- RET behaves exactly as NEXT.

## Test plan
- **Reset:** reset, then release → `pc`=0, `instr_ready`=1, `en_bar`=1, `cond_d`=8'h80, `done`=0.
- **Wrap and latency:** `pc`=8'hFF, NEXT → `pc`=8'h00 after edge k+1, `taken`=0, `done` high exactly one cycle, next accept at edge k+3.
- **Branch on Z:**
  - Load Z=1; BRANCH `cond_sel`=0, `jump_addr`=8'h3C → `en_bar`=0 and `sel`=000 during SELECT, `pc`=8'h3C, `taken`=1.
  - Repeat with Z=0 → `pc`+1, `taken`=0.
- **Flag-load race:** `flags_load` asserted with `c_in`=1 on the SELECT→DONE edge, BRANCH `cond_sel`=2, old C=0 → branch not taken; the next identical BRANCH is taken.
- **Handshake and reset:**
  - `instr_valid` held high through DONE → ignored, exactly one instruction executed.
  - `rst` during SELECT → `pc`=0, no `done` pulse.
- **Call/return (with `BRANCH_CALL_EN`):**
  - CALL `cond_sel`=7, `jump_addr`=8'h80 at `pc`=8'h10 → `pc`=8'h80; RET → `pc`=8'h11, `taken`=1.
  - A second RET → `pc`=8'h12, `taken`=0.
  - Without the macro, RET → `pc`+1.
